// File: rtl/branch_sched_pkg.sv
// Shared definitions for the ID-stage branch sequencer: branch classes,
// FSM state encoding, link register index and the branch offset helper.
// No logic of its own; imported by branch_cond and branch_sched.
package branch_sched_pkg;

    // Branch classes delivered by the decode unpacker
    localparam logic [2:0] B_INVA = 3'd0;
    localparam logic [2:0] B_EQNE = 3'd1;
    localparam logic [2:0] B_LTGE = 3'd2;
    localparam logic [2:0] B_JUMP = 3'd3;
    localparam logic [2:0] B_JREG = 3'd4;

    // Link destination for every linking branch except JALR
    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_DS  = 2'd1,
        REDIRECT = 2'd2
    } bs_state_t;

    // PC-relative branch displacement: sign-extended word offset in bytes
    function automatic logic [31:0] br_offset(input logic [15:0] immed);
        return {{14{immed[15]}}, immed, 2'b00};
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition and target evaluation for the instruction in ID.
// Latency: purely combinational, result valid in the same cycle.
// Backpressure: none; need_ops tells the sequencer whether operands matter.
module branch_cond
    import branch_sched_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  br_type,
    input  logic [1:0]  opcode_lo,
    input  logic        rt_lsb,
    input  logic [15:0] immed,
    input  logic [25:0] index,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    output logic        taken,
    output logic [31:0] target,
    output logic        need_ops
);

    logic [31:0] pc4;

    assign pc4 = pc + 32'd4;

    // Resolve taken/target per branch class; only direct jumps ignore operands
    always_comb begin
        taken    = 1'b0;
        target   = pc4 + br_offset(immed);
        need_ops = 1'b1;
        case (br_type)
            B_EQNE: begin
                case (opcode_lo)
                    2'b00:   taken = (rs_value == rt_value);
                    2'b01:   taken = (rs_value != rt_value);
                    2'b10:   taken = ($signed(rs_value) <= 32'sd0);
                    default: taken = ($signed(rs_value) > 32'sd0);
                endcase
            end
            B_LTGE: begin
                // rt[0] selects the >=0 flavour (BGEZ/BGEZAL)
                taken = rt_lsb ? !rs_value[31] : rs_value[31];
            end
            B_JUMP: begin
                taken    = 1'b1;
                target   = {pc4[31:28], index, 2'b00};
                need_ops = 1'b0;
            end
            B_JREG: begin
                taken  = 1'b1;
                target = rs_value;
            end
            default: begin
                taken = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_sched.sv
// ID-stage branch/jump sequencer: resolves, waits out the delay slot, redirects fetch; optional stats under BRANCH_STAT_EN.
// Latency: link write 1 cycle after branch accept; redirect 1 cycle after delay-slot accept (>= 2 from branch).
// Backpressure: id_ready drops only while a branch in IDLE waits on operands_ready; nothing changes state meanwhile.
module branch_sched
    import branch_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_pc,
    input  logic        id_is_branch,
    input  logic [2:0]  id_branch_type,
    input  logic        id_is_link,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [15:0] id_immed,
    input  logic [25:0] id_index,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    input  logic        operands_ready,
    input  logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        id_squash,
    output logic        link_we,
    output logic [4:0]  link_addr,
    output logic [31:0] link_data,
    output logic [31:0] stat_branch_cnt,
    output logic [31:0] stat_taken_cnt
);

    bs_state_t   state_q, state_d;
    logic        taken_q, taken_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic        link_we_q, link_we_d;
    logic [4:0]  link_addr_q, link_addr_d;
    logic [31:0] link_data_q, link_data_d;

    logic        cond_taken;
    logic [31:0] cond_target;
    logic        cond_need_ops;
    logic        is_br;
    logic        stall;
    logic        accept;
    logic        br_accept;

    // Only the low opcode bits and rt[0] select the condition flavour
    logic        unused_fields;
    assign unused_fields = ^{id_opcode[5:2], id_rt[4:1]};

    branch_cond u_cond (
        .pc        (id_pc),
        .br_type   (id_branch_type),
        .opcode_lo (id_opcode[1:0]),
        .rt_lsb    (id_rt[0]),
        .immed     (id_immed),
        .index     (id_index),
        .rs_value  (rs_value),
        .rt_value  (rt_value),
        .taken     (cond_taken),
        .target    (cond_target),
        .need_ops  (cond_need_ops)
    );

    // Branch flags only count in IDLE: the delay slot and a squashed
    // instruction are always handled as plain instructions.
    assign is_br     = id_is_branch && (state_q == IDLE);
    assign stall     = id_valid && is_br && cond_need_ops && !operands_ready;
    assign id_ready  = !rst && !stall;
    assign accept    = id_valid && id_ready;
    assign br_accept = accept && is_br;

    // Next-state and registered-output computation; flush wins over everything
    always_comb begin
        state_d          = state_q;
        taken_d          = taken_q;
        redirect_pc_d    = redirect_pc_q;
        redirect_valid_d = 1'b0;
        link_we_d        = 1'b0;
        link_addr_d      = 5'd0;
        link_data_d      = 32'd0;
        if (flush) begin
            state_d       = IDLE;
            taken_d       = 1'b0;
            redirect_pc_d = 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (br_accept) begin
                        state_d       = WAIT_DS;
                        taken_d       = cond_taken;
                        redirect_pc_d = cond_target;
                        // Link is written whether or not the branch is taken
                        if (id_is_link) begin
                            link_we_d   = 1'b1;
                            link_addr_d = (id_branch_type == B_JREG) ? id_rd : LINK_REG;
                            link_data_d = id_pc + 32'd8;
                        end
                    end
                end
                WAIT_DS: begin
                    if (accept) begin
                        if (taken_q) begin
                            state_d          = REDIRECT;
                            redirect_valid_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                REDIRECT: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            taken_q          <= 1'b0;
            redirect_pc_q    <= 32'd0;
            redirect_valid_q <= 1'b0;
            link_we_q        <= 1'b0;
            link_addr_q      <= 5'd0;
            link_data_q      <= 32'd0;
        end else begin
            state_q          <= state_d;
            taken_q          <= taken_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_valid_q <= redirect_valid_d;
            link_we_q        <= link_we_d;
            link_addr_q      <= link_addr_d;
            link_data_q      <= link_data_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign id_squash      = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign link_we        = link_we_q;
    assign link_addr      = link_addr_q;
    assign link_data      = link_data_q;

`ifdef BRANCH_STAT_EN
    logic [31:0] stat_branch_cnt_q, stat_branch_cnt_d;
    logic [31:0] stat_taken_cnt_q, stat_taken_cnt_d;

    // Count accepted (non-flushed) branches and issued redirects; wrap freely
    always_comb begin
        stat_branch_cnt_d = stat_branch_cnt_q;
        stat_taken_cnt_d  = stat_taken_cnt_q;
        if (br_accept && !flush) begin
            stat_branch_cnt_d = stat_branch_cnt_q + 32'd1;
        end
        if (redirect_valid_q) begin
            stat_taken_cnt_d = stat_taken_cnt_q + 32'd1;
        end
    end

    // Statistics survive flush; only reset clears them
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branch_cnt_q <= 32'd0;
            stat_taken_cnt_q  <= 32'd0;
        end else begin
            stat_branch_cnt_q <= stat_branch_cnt_d;
            stat_taken_cnt_q  <= stat_taken_cnt_d;
        end
    end

    assign stat_branch_cnt = stat_branch_cnt_q;
    assign stat_taken_cnt  = stat_taken_cnt_q;
`else
    assign stat_branch_cnt = 32'd0;
    assign stat_taken_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_sched.sv
// Self-checking bench for branch_sched: directed test-plan scenarios plus
// randomized branches checked against an arithmetic reference model.
// Statistics checks follow BRANCH_STAT_EN in the same way as the design.
module tb_branch_sched;

    localparam logic [2:0] T_EQNE = 3'd1;
    localparam logic [2:0] T_LTGE = 3'd2;
    localparam logic [2:0] T_JUMP = 3'd3;
    localparam logic [2:0] T_JREG = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic        id_is_branch;
    logic [2:0]  id_branch_type;
    logic        id_is_link;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [15:0] id_immed;
    logic [25:0] id_index;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic        operands_ready;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_squash;
    logic        link_we;
    logic [4:0]  link_addr;
    logic [31:0] link_data;
    logic [31:0] stat_branch_cnt;
    logic [31:0] stat_taken_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_branches = 0;
    int exp_taken    = 0;

    branch_sched dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_is_branch   (id_is_branch),
        .id_branch_type (id_branch_type),
        .id_is_link     (id_is_link),
        .id_opcode      (id_opcode),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_immed       (id_immed),
        .id_index       (id_index),
        .rs_value       (rs_value),
        .rt_value       (rt_value),
        .operands_ready (operands_ready),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_squash      (id_squash),
        .link_we        (link_we),
        .link_addr      (link_addr),
        .link_data      (link_data),
        .stat_branch_cnt(stat_branch_cnt),
        .stat_taken_cnt (stat_taken_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        id_valid       = 1'b0;
        id_pc          = 32'd0;
        id_is_branch   = 1'b0;
        id_branch_type = 3'd0;
        id_is_link     = 1'b0;
        id_opcode      = 6'd0;
        id_rt          = 5'd0;
        id_rd          = 5'd0;
        id_immed       = 16'd0;
        id_index       = 26'd0;
        rs_value       = 32'd0;
        rt_value       = 32'd0;
        operands_ready = 1'b1;
        flush          = 1'b0;
    endtask

    // Reference model: architectural MIPS branch semantics in plain arithmetic
    function automatic void model(input logic [31:0] pc, input logic [2:0] t,
                                  input logic [5:0] op, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [15:0] imm,
                                  input logic [25:0] idx, input logic [31:0] rs,
                                  input logic [31:0] rtv, output logic tk,
                                  output logic [31:0] tgt, output logic [4:0] la,
                                  output logic [31:0] ld);
        longint off;
        int     s_rs;
        s_rs = int'(rs);
        off  = longint'($signed(imm)) * 4;
        tgt  = pc + 32'd4 + 32'(off);
        tk   = 1'b0;
        case (t)
            T_EQNE: begin
                case (int'(op) % 4)
                    0:       tk = (rs == rtv);
                    1:       tk = (rs != rtv);
                    2:       tk = (s_rs <= 0);
                    default: tk = (s_rs > 0);
                endcase
            end
            T_LTGE: tk = (int'(rt) % 2 == 1) ? (s_rs >= 0) : (s_rs < 0);
            T_JUMP: begin
                tk  = 1'b1;
                tgt = ((pc + 32'd4) & 32'hF000_0000) | (32'(idx) * 32'd4);
            end
            T_JREG: begin
                tk  = 1'b1;
                tgt = rs;
            end
            default: tk = 1'b0;
        endcase
        la = (t == T_JREG) ? rd : 5'd31;
        ld = pc + 32'd8;
    endfunction

    // Full branch transaction: optional operand stall, delay-slot gap, delay slot, redirect check
    task automatic run_branch(input string nm, input logic [31:0] pc, input logic [2:0] t,
                              input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [15:0] imm, input logic [25:0] idx,
                              input logic [31:0] rs, input logic [31:0] rtv,
                              input logic lnk, input int stall, input int gap);
        logic        tk;
        logic [31:0] tgt;
        logic [4:0]  la;
        logic [31:0] ld;
        model(pc, t, op, rt, rd, imm, idx, rs, rtv, tk, tgt, la, ld);
        id_valid = 1'b1; id_is_branch = 1'b1; id_branch_type = t; id_is_link = lnk;
        id_pc = pc; id_opcode = op; id_rt = rt; id_rd = rd; id_immed = imm; id_index = idx;
        rs_value = rs; rt_value = rtv;
        if (t == T_JUMP) begin
            // Direct jumps never wait for operands
            operands_ready = (stall == 0);
            #1;
            n_checks++;
            if (id_ready !== 1'b1) begin n_fail++; $display("FAIL %s jump_ready: got %b want 1", nm, id_ready); end
        end else begin
            operands_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                #1;
                n_checks++;
                if (id_ready !== 1'b0) begin n_fail++; $display("FAIL %s stall_ready[%0d]: got %b want 0", nm, i, id_ready); end
                n_checks++;
                if (link_we !== 1'b0 || redirect_valid !== 1'b0) begin
                    n_fail++; $display("FAIL %s stall_quiet[%0d]: link_we %b redirect %b want 0 0", nm, i, link_we, redirect_valid);
                end
                step;
            end
            operands_ready = 1'b1;
            #1;
            n_checks++;
            if (id_ready !== 1'b1) begin n_fail++; $display("FAIL %s accept_ready: got %b want 1", nm, id_ready); end
        end
        step;
        exp_branches++;
        idle_inputs;
        rs_value = $urandom;
        n_checks++;
        if (link_we !== lnk) begin n_fail++; $display("FAIL %s link_we: got %b want %b", nm, link_we, lnk); end
        if (lnk) begin
            n_checks++;
            if (link_addr !== la) begin n_fail++; $display("FAIL %s link_addr: got %0d want %0d", nm, link_addr, la); end
            n_checks++;
            if (link_data !== ld) begin n_fail++; $display("FAIL %s link_data: got %h want %h", nm, link_data, ld); end
        end
        n_checks++;
        if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL %s early_redirect: got %b want 0", nm, redirect_valid); end
        for (int g = 0; g < gap; g++) begin
            step;
            n_checks++;
            if (redirect_valid !== 1'b0 || link_we !== 1'b0) begin
                n_fail++; $display("FAIL %s gap_quiet[%0d]: redirect %b link_we %b want 0 0", nm, g, redirect_valid, link_we);
            end
        end
        // Delay slot carrying branch-like flags and missing operands: still plain
        id_valid = 1'b1; id_is_branch = 1'($urandom_range(0, 1)); id_branch_type = T_JREG;
        operands_ready = 1'b0;
        #1;
        n_checks++;
        if (id_ready !== 1'b1) begin n_fail++; $display("FAIL %s ds_ready: got %b want 1", nm, id_ready); end
        step;
        idle_inputs;
        n_checks++;
        if (redirect_valid !== tk || id_squash !== tk) begin
            n_fail++; $display("FAIL %s redirect: valid %b squash %b want %b", nm, redirect_valid, id_squash, tk);
        end
        if (tk) begin
            exp_taken++;
            n_checks++;
            if (redirect_pc !== tgt) begin n_fail++; $display("FAIL %s redirect_pc: got %h want %h", nm, redirect_pc, tgt); end
        end
        step;
        n_checks++;
        if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL %s redirect_width: got %b want 0", nm, redirect_valid); end
    endtask

    task automatic test_reset;
        idle_inputs;
        rst = 1'b1;
        id_valid = 1'b1; id_is_branch = 1'b1; id_branch_type = T_JUMP;
        step; step;
        n_checks++;
        if (id_ready !== 1'b0) begin n_fail++; $display("FAIL reset id_ready: got %b want 0", id_ready); end
        n_checks++;
        if ({redirect_valid, id_squash, link_we} !== 3'b000) begin
            n_fail++; $display("FAIL reset flags: got %b want 000", {redirect_valid, id_squash, link_we});
        end
        n_checks++;
        if (redirect_pc !== 32'd0 || link_addr !== 5'd0 || link_data !== 32'd0) begin
            n_fail++; $display("FAIL reset data: pc %h addr %0d data %h want 0", redirect_pc, link_addr, link_data);
        end
        n_checks++;
        if (stat_branch_cnt !== 32'd0 || stat_taken_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset stats: %0d %0d want 0 0", stat_branch_cnt, stat_taken_cnt);
        end
        idle_inputs;
        rst = 1'b0;
        step;
        exp_branches = 0;
        exp_taken    = 0;
    endtask

    task automatic test_beq_taken;
        run_branch("beq", 32'h100, T_EQNE, 6'd4, 5'd0, 5'd0, 16'h0004, 26'd0, 32'd5, 32'd5, 1'b0, 0, 0);
    endtask

    // BNE not taken followed immediately by J: the jump proves the FSM is back in IDLE
    task automatic test_back_to_back;
        run_branch("bne", 32'h100, T_EQNE, 6'd5, 5'd0, 5'd0, 16'h0004, 26'd0, 32'd5, 32'd5, 1'b0, 1, 2);
        run_branch("j_after_bne", 32'h1000_0000, T_JUMP, 6'd2, 5'd0, 5'd0, 16'd0, 26'h3FF_FFFF, 32'd0, 32'd0, 1'b0, 0, 0);
    endtask

    task automatic test_jal;
        run_branch("jal", 32'h0040_0000, T_JUMP, 6'd3, 5'd0, 5'd0, 16'h0100, 26'h000_0100, 32'd0, 32'd0, 1'b1, 1, 1);
    endtask

    task automatic test_jalr_stall;
        run_branch("jalr", 32'h0000_2000, T_JREG, 6'd0, 5'd0, 5'd4, 16'h2009, 26'd0, 32'h8000_0000, 32'd0, 1'b1, 3, 0);
    endtask

    task automatic test_flush;
        // BLTZ taken, then flushed while waiting for the delay slot
        idle_inputs;
        id_valid = 1'b1; id_is_branch = 1'b1; id_branch_type = T_LTGE; id_opcode = 6'd1;
        id_rt = 5'd0; id_pc = 32'h200; id_immed = 16'h0010; rs_value = 32'hFFFF_FFFF;
        step;
        exp_branches++;
        idle_inputs;
        flush = 1'b1;
        step;
        flush = 1'b0;
        id_valid = 1'b1;
        step;
        idle_inputs;
        n_checks++;
        if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wait_ds: redirect %b want 0", redirect_valid); end
        step;
        n_checks++;
        if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wait_ds_late: redirect %b want 0", redirect_valid); end
        // Flush in the same cycle as a JAL acceptance cancels the link write
        id_valid = 1'b1; id_is_branch = 1'b1; id_branch_type = T_JUMP; id_is_link = 1'b1;
        id_pc = 32'h300; id_index = 26'h40; flush = 1'b1;
        step;
        idle_inputs;
        n_checks++;
        if (link_we !== 1'b0) begin n_fail++; $display("FAIL flush_accept link_we: got %b want 0", link_we); end
        run_branch("j_after_flush", 32'h400, T_JUMP, 6'd2, 5'd0, 5'd0, 16'd0, 26'h123, 32'd0, 32'd0, 1'b0, 0, 0);
    endtask

    task automatic test_bgezal;
        run_branch("bgezal", 32'h500, T_LTGE, 6'd1, 5'h11, 5'd0, 16'hFFF0, 26'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 0, 1);
    endtask

    task automatic test_random;
        logic [2:0]  t;
        logic [31:0] rs, rtv;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                // Plain instruction in IDLE: must pass straight through
                id_valid = 1'b1; operands_ready = 1'b0; id_branch_type = T_EQNE;
                #1;
                n_checks++;
                if (id_ready !== 1'b1) begin n_fail++; $display("FAIL rnd plain_ready[%0d]: got %b want 1", n, id_ready); end
                step;
                idle_inputs;
                n_checks++;
                if (link_we !== 1'b0 || redirect_valid !== 1'b0) begin
                    n_fail++; $display("FAIL rnd plain_quiet[%0d]: link_we %b redirect %b want 0 0", n, link_we, redirect_valid);
                end
            end
            t   = 3'($urandom_range(1, 4));
            rtv = $urandom;
            case ($urandom_range(0, 3))
                0:       rs = 32'd0;
                1:       rs = rtv;
                2:       rs = 32'hFFFF_FFFF;
                default: rs = $urandom;
            endcase
            run_branch($sformatf("rnd%0d", n), $urandom & 32'hFFFF_FFFC, t,
                       6'($urandom_range(4, 7)), 5'($urandom), 5'($urandom), 16'($urandom),
                       26'($urandom), rs, rtv, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_stats;
`ifdef BRANCH_STAT_EN
        n_checks++;
        if (stat_branch_cnt !== 32'(exp_branches) || stat_taken_cnt !== 32'(exp_taken)) begin
            n_fail++; $display("FAIL stats_running: got %0d/%0d want %0d/%0d", stat_branch_cnt, stat_taken_cnt, exp_branches, exp_taken);
        end
        rst = 1'b1;
        step;
        rst = 1'b0;
        exp_branches = 0;
        exp_taken    = 0;
        run_branch("st_beq", 32'h100, T_EQNE, 6'd4, 5'd0, 5'd0, 16'h0004, 26'd0, 32'd7, 32'd7, 1'b0, 0, 0);
        run_branch("st_bne", 32'h100, T_EQNE, 6'd5, 5'd0, 5'd0, 16'h0004, 26'd0, 32'd7, 32'd7, 1'b0, 0, 0);
        run_branch("st_j", 32'h100, T_JUMP, 6'd2, 5'd0, 5'd0, 16'd0, 26'h40, 32'd0, 32'd0, 1'b0, 0, 0);
        n_checks++;
        if (stat_branch_cnt !== 32'd3 || stat_taken_cnt !== 32'd2) begin
            n_fail++; $display("FAIL stats_3_2: got %0d/%0d want 3/2", stat_branch_cnt, stat_taken_cnt);
        end
        force dut.stat_branch_cnt_q = 32'hFFFF_FFFF;
        force dut.stat_taken_cnt_q  = 32'hFFFF_FFFF;
        #1;
        release dut.stat_branch_cnt_q;
        release dut.stat_taken_cnt_q;
        run_branch("st_wrap", 32'h800, T_JUMP, 6'd2, 5'd0, 5'd0, 16'd0, 26'h80, 32'd0, 32'd0, 1'b0, 0, 0);
        n_checks++;
        if (stat_branch_cnt !== 32'd0 || stat_taken_cnt !== 32'd0) begin
            n_fail++; $display("FAIL stats_wrap: got %h/%h want 0/0", stat_branch_cnt, stat_taken_cnt);
        end
`else
        n_checks++;
        if (stat_branch_cnt !== 32'd0 || stat_taken_cnt !== 32'd0) begin
            n_fail++; $display("FAIL stats_tied: got %0d/%0d want 0/0", stat_branch_cnt, stat_taken_cnt);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_beq_taken;
        test_back_to_back;
        test_jal;
        test_jalr_stall;
        test_flush;
        test_bgezal;
        test_random;
        test_stats;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
